spc3: RTL

Parametrised successor to the fixed 16-bit serial-to-parallel configuration register. It receives addressed, parity-protected configuration frames over a serial pin and commits each frame on an explicit strobe into one of `NCH` shadow registers. Each shadow register drives one analog front-end channel (frequency select, gains, enables). A serial output supports daisy-chaining several chips on one configuration line.

---
 rtl/spc_pkg.sv | 40 ++++
 rtl/spc_frame_rx.sv | 58 +++++
 rtl/spc3.sv | 101 ++++++++++
 3 files changed

// File: rtl/spc_pkg.sv
// Shared definitions for the spc3 configuration receiver: frame-field layout,
// address-width helper and front-end reset defaults.
package spc_pkg;

    typedef enum logic [1:0] {
        COMMIT_NONE = 2'd0,
        COMMIT_OK   = 2'd1,
        COMMIT_REJ  = 2'd2
    } commit_e;

    // A single channel still needs a one-bit address field in the frame.
    function automatic int spc_aw(input int nch);
        return (nch <= 2) ? 1 : $clog2(nch);
    endfunction

    function automatic int spc_data_lsb();
        return 0;
    endfunction

    function automatic int spc_addr_lsb(input int w);
        return w;
    endfunction

    function automatic int spc_par_pos(input int w, input int aw);
        return w + aw;
    endfunction

    function automatic int spc_frame_len(input int w, input int aw);
        return w + aw + 1;
    endfunction

    // Front-end word fields: [3:0] frequency select, [7:4] gain 1,
    // [11:8] gain 2, [15:12] channel enables. All start disabled/lowest.
    localparam logic [3:0]  FE_FSEL_DEF  = 4'h0;
    localparam logic [3:0]  FE_GAIN1_DEF = 4'h0;
    localparam logic [3:0]  FE_GAIN2_DEF = 4'h0;
    localparam logic [3:0]  FE_EN_DEF    = 4'h0;
    localparam logic [15:0] SPC_RST_VAL  = {FE_EN_DEF, FE_GAIN2_DEF, FE_GAIN1_DEF, FE_FSEL_DEF};

endpackage

// File: rtl/spc_frame_rx.sv
// Serial frame receiver: LSB-first shift register, saturating bit counter and
// the length/parity/address validity check presented to the commit logic.
module spc_frame_rx
    import spc_pkg::*;
#(
    parameter int W   = 16,
    parameter int NCH = 4,
    parameter int AW  = spc_aw(NCH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cfg_in,
    input  logic          cfg_en,
    input  logic          strobe,
    output logic          cfg_out,
    output logic          frame_ok,
    output logic [W-1:0]  data,
    output logic [AW-1:0] addr
);

    localparam int FRAME = spc_frame_len(W, AW);
    localparam int CW    = $clog2(FRAME + 2);
    localparam int DL    = spc_data_lsb();
    localparam int AL    = spc_addr_lsb(W);
    localparam int PP    = spc_par_pos(W, AW);

    logic [FRAME-1:0] sr_reg;
    logic [CW-1:0]    cnt_reg;
    logic             len_ok;
    logic             par_even;
    logic             addr_ok;

    // A commit always wins over shifting; the bit offered in that cycle is dropped.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sr_reg  <= '0;
            cnt_reg <= '0;
        end else if (strobe) begin
            cnt_reg <= '0;
        end else if (cfg_en) begin
            sr_reg <= {cfg_in, sr_reg[FRAME-1:1]};
            if (cnt_reg != CW'(FRAME + 1)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign data    = sr_reg[DL +: W];
    assign addr    = sr_reg[AL +: AW];
    assign cfg_out = sr_reg[0];

    // Count saturates one past FRAME so any overrun can never alias back to FRAME.
    assign len_ok   = (cnt_reg == CW'(FRAME));
    assign par_even = ~(^sr_reg[PP-1:0] ^ sr_reg[PP]);
    assign addr_ok  = ({1'b0, addr} < (AW + 1)'(NCH));
    assign frame_ok = len_ok & par_even & addr_ok;

endmodule

// File: rtl/spc3.sv
// Addressed serial configuration register: receives parity-protected frames and
// commits them on Strobe into one of NCH shadow words driving the front-end.
module spc3
    import spc_pkg::*;
#(
    parameter int           W       = 16,
    parameter int           NCH     = 4,
    parameter logic [W-1:0] RST_VAL = W'(SPC_RST_VAL),
    localparam int          AW      = spc_aw(NCH)
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             Cfg_in,
    input  logic             Cfg_en,
    input  logic             Strobe,
    output logic             Cfg_out,
    output logic [NCH*W-1:0] Cfg_word,
    output logic             Update,
    output logic [AW-1:0]    Upd_ch,
    output logic             Err
);

    logic          frame_ok;
    logic [W-1:0]  rx_data;
    logic [AW-1:0] rx_addr;
    commit_e       commit_res;

    logic          update_reg;
    logic [AW-1:0] upd_ch_reg;
    logic          err_reg;

    spc_frame_rx #(
        .W   (W),
        .NCH (NCH),
        .AW  (AW)
    ) u_rx (
        .clk      (Clk),
        .resetn   (Resetn),
        .cfg_in   (Cfg_in),
        .cfg_en   (Cfg_en),
        .strobe   (Strobe),
        .cfg_out  (Cfg_out),
        .frame_ok (frame_ok),
        .data     (rx_data),
        .addr     (rx_addr)
    );

    always_comb begin
        commit_res = COMMIT_NONE;
        if (Strobe) begin
            commit_res = frame_ok ? COMMIT_OK : COMMIT_REJ;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [W-1:0] word_reg;
            logic         hit;

            assign hit = (commit_res == COMMIT_OK) && (rx_addr == AW'(gi));

            always_ff @(posedge Clk) begin
                if (!Resetn) begin
                    word_reg <= RST_VAL;
                end else if (hit) begin
                    word_reg <= rx_data;
                end
            end

            assign Cfg_word[gi*W +: W] = word_reg;
        end
    endgenerate

    // Upd_ch keeps pointing at the last good write even after a rejected commit.
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            update_reg <= 1'b0;
            upd_ch_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            update_reg <= 1'b0;
            unique case (commit_res)
                COMMIT_OK: begin
                    update_reg <= 1'b1;
                    upd_ch_reg <= rx_addr;
                    err_reg    <= 1'b0;
                end
                COMMIT_REJ: begin
                    err_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Update = update_reg;
    assign Upd_ch = upd_ch_reg;
    assign Err    = err_reg;

endmodule
